// File: rtl/keypad_pkg.sv
// Shared types, key codes and the (row, col) to key-code map for the keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN         = 2'd0,
    DEBOUNCE     = 2'd1,
    PRESS        = 2'd2,
    WAIT_RELEASE = 2'd3
  } scan_state_e;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  localparam logic [3:0] ROW_IDLE = 4'b1110;
  localparam logic [3:0] COL_IDLE = 4'hF;

  function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'd0;
    case ({row, col})
      4'h0: code = 4'd1;
      4'h1: code = 4'd2;
      4'h2: code = 4'd3;
      4'h3: code = KEY_A;
      4'h4: code = 4'd4;
      4'h5: code = 4'd5;
      4'h6: code = 4'd6;
      4'h7: code = KEY_B;
      4'h8: code = 4'd7;
      4'h9: code = 4'd8;
      4'hA: code = 4'd9;
      4'hB: code = KEY_C;
      4'hC: code = KEY_STAR;
      4'hD: code = 4'd0;
      4'hE: code = KEY_HASH;
      4'hF: code = KEY_D;
      default: code = 4'd0;
    endcase
    return code;
  endfunction

  // True when exactly one column is pulled low; multi-key ghosts return false.
  function automatic logic one_low(input logic [3:0] cols);
    return (cols == 4'b1110) || (cols == 4'b1101) || (cols == 4'b1011) || (cols == 4'b0111);
  endfunction

  function automatic logic [1:0] col_index(input logic [3:0] cols);
    logic [1:0] idx;
    idx = 2'd0;
    case (cols)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// Two-flop synchronizer for the asynchronous keypad column lines; idles at all-released.
module keypad_col_sync
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_n,
  output logic [3:0] col_s
);

  logic [3:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta  <= COL_IDLE;
      col_s <= COL_IDLE;
    end else begin
      meta  <= col_n;
      col_s <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner with debounce; one key_valid strobe per accepted press.
// Optional auto-repeat while a key is held: define KEYPAD_AUTOREPEAT_EN.
//
// state        | meaning
// SCAN         | rotate rows, sample columns on the last cycle of each row slot
// DEBOUNCE     | row frozen, require DEBOUNCE_CYC matching samples of the captured column
// PRESS        | single-cycle key_valid strobe, key_code updated
// WAIT_RELEASE | row frozen, wait for DEBOUNCE_CYC consecutive idle samples
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV      = 1000,
  parameter int DEBOUNCE_CYC  = 20000
`ifdef KEYPAD_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 50000,
  parameter int REPEAT_PERIOD = 10000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);

  scan_state_e       state, state_nxt;
  logic [3:0]        col_s;
  logic [1:0]        row_idx, row_idx_nxt;
  logic [SCAN_W-1:0] scan_cnt, scan_cnt_nxt;
  logic [DB_W-1:0]   db_cnt, db_cnt_nxt;
  logic [3:0]        cap_cols, cap_cols_nxt;
  logic [3:0]        code_q, code_nxt;
  logic              rep_fire;

  keypad_col_sync u_col_sync (
    .clk   (clk),
    .reset (reset),
    .col_n (col_n),
    .col_s (col_s)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= SCAN;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_idx  <= 2'd0;
      scan_cnt <= '0;
      db_cnt   <= '0;
      cap_cols <= COL_IDLE;
      code_q   <= 4'd0;
    end else begin
      row_idx  <= row_idx_nxt;
      scan_cnt <= scan_cnt_nxt;
      db_cnt   <= db_cnt_nxt;
      cap_cols <= cap_cols_nxt;
      code_q   <= code_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    row_idx_nxt  = row_idx;
    scan_cnt_nxt = scan_cnt;
    db_cnt_nxt   = db_cnt;
    cap_cols_nxt = cap_cols;
    code_nxt     = code_q;
    key_valid    = 1'b0;
    key_held     = 1'b0;
    case (state)
      SCAN: begin
        if (scan_cnt == SCAN_LAST) begin
          scan_cnt_nxt = '0;
          if (one_low(col_s)) begin
            cap_cols_nxt = col_s;
            db_cnt_nxt   = '0;
            state_nxt    = DEBOUNCE;
          end else begin
            row_idx_nxt = row_idx + 2'd1;
          end
        end else begin
          scan_cnt_nxt = scan_cnt + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (col_s != cap_cols) begin
          state_nxt    = SCAN;
          row_idx_nxt  = row_idx + 2'd1;
          scan_cnt_nxt = '0;
        end else if (db_cnt == DB_LAST) begin
          state_nxt = PRESS;
          code_nxt  = keymap(row_idx, col_index(cap_cols));
        end else begin
          db_cnt_nxt = db_cnt + 1'b1;
        end
      end
      PRESS: begin
        key_valid  = 1'b1;
        key_held   = 1'b1;
        db_cnt_nxt = '0;
        state_nxt  = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        key_held = 1'b1;
        // Any non-idle sample (including a second key in this row) restarts the release count.
        if (col_s == COL_IDLE) begin
          if (db_cnt == DB_LAST) begin
            state_nxt    = SCAN;
            row_idx_nxt  = row_idx + 2'd1;
            scan_cnt_nxt = '0;
            db_cnt_nxt   = '0;
          end else begin
            db_cnt_nxt = db_cnt + 1'b1;
          end
        end else begin
          db_cnt_nxt = '0;
        end
      end
      default: state_nxt = SCAN;
    endcase
    key_valid = key_valid | rep_fire;
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] rep_target;
  logic              rep_on;
  logic              rep_first;

  // hold_cnt equals cycles since PRESS (or since the previous repeat); a deviation kills repeats for good.
  assign rep_target = rep_first ? HOLD_W'(REPEAT_DELAY) : HOLD_W'(REPEAT_PERIOD);
  assign rep_fire   = (state == WAIT_RELEASE) && rep_on && (col_s == cap_cols) &&
                      (hold_cnt == rep_target);

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt  <= '0;
      rep_on    <= 1'b0;
      rep_first <= 1'b0;
    end else if (state == PRESS) begin
      hold_cnt  <= HOLD_W'(1);
      rep_on    <= 1'b1;
      rep_first <= 1'b1;
    end else if ((state == WAIT_RELEASE) && rep_on) begin
      if (col_s != cap_cols) begin
        rep_on <= 1'b0;
      end else if (rep_fire) begin
        hold_cnt  <= HOLD_W'(1);
        rep_first <= 1'b0;
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  assign row_n    = ~(~ROW_IDLE << row_idx);
  assign key_code = code_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Randomized bench for keypad_scan: physical keypad model, cycle-timed reference and event scoreboard.
module tb_keypad_scan;

  localparam int SD = 4;
  localparam int DC = 8;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RD = 40;
  localparam int RP = 12;
`endif

  localparam int M_SCAN  = 0;
  localparam int M_QUAL  = 1;
  localparam int M_PRESS = 2;
  localparam int M_HELD  = 3;

  localparam logic [3:0] CODE_OF [16] = '{4'd1, 4'd2, 4'd3, 4'd10,
                                          4'd4, 4'd5, 4'd6, 4'd11,
                                          4'd7, 4'd8, 4'd9, 4'd12,
                                          4'd14, 4'd0, 4'd15, 4'd13};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] col_n = 4'hF;
  logic [3:0] row_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  keypad_scan #(
    .SCAN_DIV      (SD),
    .DEBOUNCE_CYC  (DC)
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .col_n     (col_n),
    .row_n     (row_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] code;
  } ev_t;

  ev_t         exp_q[$];
  logic [15:0] pressed = '0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  // reference model state
  int          m_mode = M_SCAN, m_row = 0, m_slot_start = 0, m_det = 0, m_press = 0, m_rel_run = 0;
  logic [3:0]  m_cap = 4'hF, m_code = 4'd0, p1 = 4'hF, p2 = 4'hF;
  bit          m_rst_prev = 1'b1;
  bit          m_alive = 1'b0;
  logic [3:0]  e_row_n = 4'b1110;
  bit          e_held = 1'b0;
  logic [3:0]  e_code = 4'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Which columns read low, given which rows are driven low and which keys are down.
  function automatic logic [3:0] cols_seen(input logic [3:0] rows_low, input logic [15:0] keys);
    logic [3:0] c;
    c = 4'hF;
    for (int r = 0; r < 4; r++)
      if (rows_low[r] === 1'b0)
        for (int k = 0; k < 4; k++)
          if (keys[r*4+k]) c[k] = 1'b0;
    return c;
  endfunction

  function automatic int n_low(input logic [3:0] c);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) if (c[i] == 1'b0) n++;
    return n;
  endfunction

  function automatic int col_of(input logic [3:0] c);
    int idx;
    idx = 0;
    for (int i = 0; i < 4; i++) if (c[i] == 1'b0) idx = i;
    return idx;
  endfunction

  // Keypad drive plus reference model, stepped once per cycle on the falling edge.
  always @(negedge clk) begin
    logic [3:0] cs, raw, rmask;
    ev_t        ev;
    cyc++;
    col_n = cols_seen(row_n, pressed);
    if (m_rst_prev) begin
      m_mode = M_SCAN; m_row = 0; m_slot_start = cyc; m_code = 4'd0;
      p1 = 4'hF; p2 = 4'hF; m_rel_run = 0; m_alive = 1'b0;
    end
    e_row_n = 4'hF;
    e_row_n[m_row] = 1'b0;
    e_held = (m_mode == M_PRESS) || (m_mode == M_HELD);
    e_code = m_code;
    rmask = e_row_n;
    cs = p2;
    raw = cols_seen(rmask, pressed);
    p2 = p1;
    p1 = raw;
    case (m_mode)
      M_SCAN: begin
        if (cyc - m_slot_start == SD - 1) begin
          if (n_low(cs) == 1) begin
            m_cap = cs; m_det = cyc; m_mode = M_QUAL;
          end else begin
            m_row = (m_row + 1) % 4; m_slot_start = cyc + 1;
          end
        end
      end
      M_QUAL: begin
        if (cs != m_cap) begin
          m_mode = M_SCAN; m_row = (m_row + 1) % 4; m_slot_start = cyc + 1;
        end else if (cyc == m_det + DC) begin
          m_mode = M_PRESS;
          m_code = CODE_OF[m_row*4 + col_of(m_cap)];
          if (!reset) begin
            ev.cyc = cyc + 1; ev.code = m_code;
            exp_q.push_back(ev);
          end
        end
      end
      M_PRESS: begin
        m_mode = M_HELD; m_press = cyc; m_rel_run = 0; m_alive = 1'b1;
      end
      default: begin
        if (cs == 4'hF) m_rel_run++;
        else            m_rel_run = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
        if (cs != m_cap) m_alive = 1'b0;
        if (m_alive && (cyc - m_press >= RD) && ((cyc - m_press - RD) % RP == 0)) begin
          ev.cyc = cyc; ev.code = m_code;
          exp_q.push_back(ev);
        end
`endif
        if (m_rel_run == DC) begin
          m_mode = M_SCAN; m_row = (m_row + 1) % 4; m_slot_start = cyc + 1;
        end
      end
    endcase
    m_rst_prev = reset;
  end

  // Monitor: per-cycle output compare and event scoreboard.
  always @(negedge clk) begin
    ev_t ev;
    #1;
    check("row_n", {28'd0, row_n}, {28'd0, e_row_n});
    check("key_held", {31'd0, key_held}, {31'd0, e_held});
    check("key_code", {28'd0, key_code}, {28'd0, e_code});
    if (key_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_key_valid", 32'd1, 32'd0);
      end else begin
        ev = exp_q.pop_front();
        check("event_cycle", cyc, ev.cyc);
        check("event_code", {28'd0, key_code}, {28'd0, ev.code});
      end
    end
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      check("missed_key_valid", 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic assert_reset(input int n);
    reset = 1'b1;
    pressed = '0;
    repeat (n) @(posedge clk);
    #3;
    check("rst_row_n", {28'd0, row_n}, 32'h0000_000E);
    check("rst_key_valid", {31'd0, key_valid}, 32'd0);
    check("rst_key_code", {28'd0, key_code}, 32'd0);
    check("rst_key_held", {31'd0, key_held}, 32'd0);
    reset = 1'b0;
  endtask

  task automatic hold_key(input int idx, input int hold, input int idle);
    pressed = 16'(1) << idx;
    step(hold);
    pressed = '0;
    step(idle);
  endtask

  initial begin
    int found;
    assert_reset(3);
    step(40);

    hold_key(9, 60, 30);

    // bounce on '5' before a stable press
    for (int i = 0; i < 3; i++) begin
      pressed = 16'(1) << 5; step(3);
      pressed = '0;          step($urandom_range(1, 4));
    end
    hold_key(5, 50, 30);

    // ghost: two columns low on row1
    pressed = (16'(1) << 4) | (16'(1) << 6);
    step(60);
    pressed = '0;
    step(20);

    // second key in the same row while the first is held
    pressed = 16'(1) << 0; step(30);
    pressed = pressed | (16'(1) << 1); step(20);
    pressed = 16'(1) << 1; step(10);
    pressed = '0; step(30);

    // reset in the middle of debounce
    pressed = 16'(1) << 2;
    found = 0;
    for (int i = 0; i < 80 && found == 0; i++) begin
      step(1);
      if (m_mode == M_QUAL && cyc == m_det + 5) found = 1;
    end
    check("debounce_reached", found, 1);
    assert_reset(1);
    step(30);

    // long hold on '#'
    hold_key(14, 110, 30);

    // random soak
    for (int it = 0; it < 40; it++) begin
      logic [15:0] mask;
      mask = 16'(1) << $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) mask = mask | (16'(1) << $urandom_range(0, 15));
      for (int b = 0; b < int'($urandom_range(0, 3)); b++) begin
        pressed = mask; step($urandom_range(1, 6));
        pressed = '0;   step($urandom_range(1, 6));
      end
      pressed = mask;
      step($urandom_range(1, 100));
      for (int b = 0; b < int'($urandom_range(0, 2)); b++) begin
        pressed = '0;   step($urandom_range(1, 5));
        pressed = mask; step($urandom_range(1, 5));
      end
      pressed = '0;
      step($urandom_range(1, 40));
      if ($urandom_range(0, 9) == 0) begin
        assert_reset($urandom_range(1, 3));
        step(5);
      end
    end

    pressed = '0;
    step(60);
    check("pending_events", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
